alu_op_sequencer: RTL and testbench

- Controller that sequences the shared 32-bit ALU (operands RA/RB, 5-bit opcode, 64-bit RZ result) for one requester.
- Accepts one operation per valid/ready handshake and holds the ALU inputs stable for the opcode's required number of cycles.
- Captures RZ into Zlow/Zhigh and presents the result with a valid/ready handshake.
- Sits between the control unit and the ALU. Multi-cycle ops (MUL/DIV) are timed here, not in the ALU.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_op_decode.sv | 19 +
 rtl/alu_op_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, FSM state encoding and opcode classification
// helpers shared by the ALU operation sequencer and its decoder.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_SHR  = 5'h04;
    localparam logic [4:0] OP_SHRA = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_ROR  = 5'h07;
    localparam logic [4:0] OP_ROL  = 5'h08;
    localparam logic [4:0] OP_MUL  = 5'h09;
    localparam logic [4:0] OP_DIV  = 5'h0A;
    localparam logic [4:0] OP_NEG  = 5'h0B;
    localparam logic [4:0] OP_NOT  = 5'h0C;
    localparam logic [4:0] OP_LAST = OP_NOT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Legal opcodes form one contiguous range starting at ADD.
    function automatic logic op_is_legal(input logic [4:0] op);
        return (op <= OP_LAST);
    endfunction

    // MUL and DIV are the only ops that need the long hold time.
    function automatic logic op_is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational opcode classifier used by the
// sequencer to pick the hold time and detect error cases.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [4:0] i_opcode,
    output logic       o_is_legal,
    output logic       o_is_muldiv,
    output logic       o_is_div
);

    // Classify the incoming opcode.
    always_comb begin
        o_is_legal  = op_is_legal(i_opcode);
        o_is_muldiv = op_is_muldiv(i_opcode);
        o_is_div    = (i_opcode == OP_DIV);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU operation per valid/ready handshake,
// holds the shared ALU inputs for the opcode's hold time, captures RZ into
// zlow/zhigh and returns it with a valid/ready handshake.
// Optional build macro ALU_SEQ_STATS_EN adds op_count / busy_cycles outputs.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MULDIV_LAT = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [4:0]          req_opcode,
    input  logic [DATA_W-1:0]   req_ra,
    input  logic [DATA_W-1:0]   req_rb,
    output logic [DATA_W-1:0]   alu_ra,
    output logic [DATA_W-1:0]   alu_rb,
    output logic [4:0]          alu_opcode,
    input  logic [2*DATA_W-1:0] alu_rz,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   zlow,
    output logic [DATA_W-1:0]   zhigh,
    output logic                err_illegal,
    output logic                err_div0
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0]         op_count,
    output logic [31:0]         busy_cycles
`endif
);

    // Counter only needs to hold the larger of the two reload values.
    localparam int MAX_LAT = (MULDIV_LAT > ALU_LAT) ? MULDIV_LAT : ALU_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] ALU_LOAD    = CNT_W'(ALU_LAT - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_alu_ra;
    logic [DATA_W-1:0]   r_alu_rb;
    logic [4:0]          r_alu_opcode;
    logic [DATA_W-1:0]   r_zlow;
    logic [DATA_W-1:0]   r_zhigh;
    logic                r_err_illegal;
    logic                r_err_div0;

    logic                w_is_legal;
    logic                w_is_muldiv;
    logic                w_is_div;
    logic                w_rb_zero;

    alu_op_decode u_decode (
        .i_opcode    (req_opcode),
        .o_is_legal  (w_is_legal),
        .o_is_muldiv (w_is_muldiv),
        .o_is_div    (w_is_div)
    );

    assign w_rb_zero = (req_rb == '0);

    // Control FSM with registered handshake, ALU-input and result outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_alu_ra      <= '0;
            r_alu_rb      <= '0;
            r_alu_opcode  <= OP_ADD;
            r_zlow        <= '0;
            r_zhigh       <= '0;
            r_err_illegal <= 1'b0;
            r_err_div0    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!w_is_legal) begin
                            // Never reaches the ALU; report straight away.
                            r_zlow        <= '0;
                            r_zhigh       <= '0;
                            r_err_illegal <= 1'b1;
                            r_err_div0    <= 1'b0;
                            r_req_ready   <= 1'b0;
                            r_resp_valid  <= 1'b1;
                            r_state       <= ST_DONE;
                        end else if (w_is_div && w_rb_zero) begin
                            // Divide by zero is trapped here, ALU inputs untouched.
                            r_zlow        <= '0;
                            r_zhigh       <= '0;
                            r_err_illegal <= 1'b0;
                            r_err_div0    <= 1'b1;
                            r_req_ready   <= 1'b0;
                            r_resp_valid  <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_alu_opcode <= req_opcode;
                            r_alu_ra     <= req_ra;
                            r_alu_rb     <= req_rb;
                            r_cnt        <= w_is_muldiv ? MULDIV_LOAD : ALU_LOAD;
                            r_req_ready  <= 1'b0;
                            r_state      <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Hold time satisfied: RZ is settled, split it bit-exactly.
                        r_zlow        <= alu_rz[DATA_W-1:0];
                        r_zhigh       <= alu_rz[2*DATA_W-1:DATA_W];
                        r_err_illegal <= 1'b0;
                        r_err_div0    <= 1'b0;
                        r_resp_valid  <= 1'b1;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Always pass through IDLE before the next accept.
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [31:0] r_op_count;
    logic [31:0] r_busy_cycles;

    // Completed-response and non-idle cycle counters, free-running wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op_count    <= '0;
            r_busy_cycles <= '0;
        end else begin
            if ((r_state == ST_DONE) && resp_ready) begin
                r_op_count <= r_op_count + 32'd1;
            end
            if (r_state != ST_IDLE) begin
                r_busy_cycles <= r_busy_cycles + 32'd1;
            end
        end
    end

    assign op_count    = r_op_count;
    assign busy_cycles = r_busy_cycles;
`endif

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign alu_ra      = r_alu_ra;
    assign alu_rb      = r_alu_rb;
    assign alu_opcode  = r_alu_opcode;
    assign zlow        = r_zlow;
    assign zhigh       = r_zhigh;
    assign err_illegal = r_err_illegal;
    assign err_div0    = r_err_div0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized scenarios for the ALU
// operation sequencer, with a behavioural ALU attached to its outputs.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DATA_W     = 32;
    localparam int MULDIV_LAT = 4;
    localparam int ALU_LAT    = 1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_opcode = 5'd0;
    logic [31:0] req_ra = 32'd0;
    logic [31:0] req_rb = 32'd0;
    logic [31:0] alu_ra;
    logic [31:0] alu_rb;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_rz;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] zlow;
    logic [31:0] zhigh;
    logic        err_illegal;
    logic        err_div0;
`ifdef ALU_SEQ_STATS_EN
    logic [31:0] op_count;
    logic [31:0] busy_cycles;
`endif

    int errors = 0;
    int checks = 0;

    // Bench-side record of the last operation that actually reached the ALU.
    logic [4:0]  m_op = OP_ADD;
    logic [31:0] m_ra = 32'd0;
    logic [31:0] m_rb = 32'd0;

    alu_op_sequencer #(
        .DATA_W     (DATA_W),
        .MULDIV_LAT (MULDIV_LAT),
        .ALU_LAT    (ALU_LAT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_ra      (req_ra),
        .req_rb      (req_rb),
        .alu_ra      (alu_ra),
        .alu_rb      (alu_rb),
        .alu_opcode  (alu_opcode),
        .alu_rz      (alu_rz),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .zlow        (zlow),
        .zhigh       (zhigh),
        .err_illegal (err_illegal),
        .err_div0    (err_div0)
`ifdef ALU_SEQ_STATS_EN
        ,
        .op_count    (op_count),
        .busy_cycles (busy_cycles)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural ALU: what the real datapath computes for each opcode.
    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] aa;
        logic [63:0] t;
        logic [31:0] q;
        logic [31:0] r;
        aa = {a, a};
        case (op)
            5'h00: return {32'd0, a + b};
            5'h01: return {32'd0, a - b};
            5'h02: return {32'd0, a & b};
            5'h03: return {32'd0, a | b};
            5'h04: return {32'd0, a >> b[4:0]};
            5'h05: begin
                q = $signed(a) >>> b[4:0];
                return {32'd0, q};
            end
            5'h06: return {32'd0, a << b[4:0]};
            5'h07: begin
                t = aa >> b[4:0];
                return {32'd0, t[31:0]};
            end
            5'h08: begin
                t = aa << b[4:0];
                return {32'd0, t[63:32]};
            end
            5'h09: return {{32{a[31]}}, a} * {{32{b[31]}}, b};
            5'h0A: begin
                if (b == 32'd0) return 64'd0;
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            5'h0B: return {32'd0, 32'd0 - a};
            5'h0C: return {32'd0, ~a};
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    always_comb alu_rz = alu_ref(alu_opcode, alu_ra, alu_rb);

    // Present one request, then count edges (accept edge included) until resp_valid.
    task automatic send_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        req_valid = 1'b1;
        req_opcode = op;
        req_ra = a;
        req_rb = b;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: req_ready=%b resp_valid=%b, required 1/0", req_ready, resp_valid);
        end
        checks++;
        if (zlow !== 32'd0 || zhigh !== 32'd0 || err_illegal !== 1'b0 || err_div0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: zlow=%h zhigh=%h ill=%b div0=%b, required all 0", zlow, zhigh, err_illegal, err_div0);
        end
        checks++;
        if (alu_ra !== 32'd0 || alu_rb !== 32'd0 || alu_opcode !== OP_ADD) begin
            errors++;
            $display("FAIL reset_alu: ra=%h rb=%h op=%h, required 0/0/00", alu_ra, alu_rb, alu_opcode);
        end
`ifdef ALU_SEQ_STATS_EN
        checks++;
        if (op_count !== 32'd0 || busy_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: op_count=%0d busy=%0d, required 0/0", op_count, busy_cycles);
        end
`endif
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_add_basic();
        int lat;
        send_req(OP_ADD, 32'h0444_4444, 32'h0444_4444, lat);
        m_op = OP_ADD; m_ra = 32'h0444_4444; m_rb = 32'h0444_4444;
        checks++;
        if (lat !== ALU_LAT + 1) begin
            errors++;
            $display("FAIL add_latency: edges=%0d, required %0d", lat, ALU_LAT + 1);
        end
        checks++;
        if (resp_valid !== 1'b1 || zlow !== 32'h0888_8888 || err_illegal !== 1'b0 || err_div0 !== 1'b0) begin
            errors++;
            $display("FAIL add_result: valid=%b zlow=%h ill=%b div0=%b, required 1/08888888/0/0", resp_valid, zlow, err_illegal, err_div0);
        end
        take_resp();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_return_idle: req_ready=%b resp_valid=%b, required 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:1] rv;
        resp_ready = 1'b1;
        req_valid = 1'b1;
        req_opcode = OP_ADD; req_ra = 32'hFFFF_FFF0; req_rb = 32'hFFFF_FFF8;
        @(posedge clock); #1;
        req_opcode = OP_SUB; req_ra = 32'd16; req_rb = 32'd8;
        rv[1] = resp_valid;
        @(posedge clock); #1;
        rv[2] = resp_valid;
        checks++;
        if (zlow !== 32'hFFFF_FFE8) begin
            errors++;
            $display("FAIL b2b_add_zlow: zlow=%h, required FFFFFFE8", zlow);
        end
        @(posedge clock); #1;
        rv[3] = resp_valid;
        checks++;
        if (req_ready !== 1'b1 || alu_opcode !== OP_ADD) begin
            errors++;
            $display("FAIL b2b_no_accept_in_done: req_ready=%b alu_op=%h, required 1/00", req_ready, alu_opcode);
        end
        @(posedge clock); #1;
        rv[4] = resp_valid;
        req_valid = 1'b0;
        checks++;
        if (alu_opcode !== OP_SUB || alu_ra !== 32'd16 || alu_rb !== 32'd8) begin
            errors++;
            $display("FAIL b2b_sub_accept: op=%h ra=%h rb=%h, required 01/10/08", alu_opcode, alu_ra, alu_rb);
        end
        @(posedge clock); #1;
        rv[5] = resp_valid;
        checks++;
        if (zlow !== 32'h0000_0008) begin
            errors++;
            $display("FAIL b2b_sub_zlow: zlow=%h, required 00000008", zlow);
        end
        checks++;
        if (rv !== 5'b10010) begin
            errors++;
            $display("FAIL b2b_valid_pattern: resp_valid[5:1]=%b, required 10010", rv);
        end
        @(posedge clock); #1;
        resp_ready = 1'b0;
        m_op = OP_SUB; m_ra = 32'd16; m_rb = 32'd8;
    endtask

    task automatic test_mul();
        logic bad;
        req_valid = 1'b1;
        req_opcode = OP_MUL; req_ra = 32'd16; req_rb = 32'hFFFF_FFF8;
        @(posedge clock); #1;
        req_valid = 1'b0;
        m_op = OP_MUL; m_ra = 32'd16; m_rb = 32'hFFFF_FFF8;
        bad = 1'b0;
        for (int i = 1; i <= MULDIV_LAT; i++) begin
            if (alu_opcode !== OP_MUL || alu_ra !== 32'd16 || alu_rb !== 32'hFFFF_FFF8 ||
                req_ready !== 1'b0 || resp_valid !== 1'b0) bad = 1'b1;
            @(posedge clock); #1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mul_hold: inputs/handshake changed during hold, now op=%h ra=%h rb=%h", alu_opcode, alu_ra, alu_rb);
        end
        checks++;
        if (resp_valid !== 1'b1 || {zhigh, zlow} !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++;
            $display("FAIL mul_result: valid=%b z=%h_%h, required 1/FFFFFFFF_FFFFFF80", resp_valid, zhigh, zlow);
        end
        take_resp();
    endtask

    task automatic test_div();
        int lat;
        send_req(OP_DIV, 32'd17, 32'd5, lat);
        m_op = OP_DIV; m_ra = 32'd17; m_rb = 32'd5;
        checks++;
        if (lat !== MULDIV_LAT + 1 || zlow !== 32'd3 || zhigh !== 32'd2 || err_div0 !== 1'b0) begin
            errors++;
            $display("FAIL div_result: edges=%0d zlow=%h zhigh=%h div0=%b, required %0d/3/2/0", lat, zlow, zhigh, err_div0, MULDIV_LAT + 1);
        end
        take_resp();
        send_req(OP_DIV, 32'd17, 32'd0, lat);
        checks++;
        if (lat !== 1 || err_div0 !== 1'b1 || err_illegal !== 1'b0 || zlow !== 32'd0 || zhigh !== 32'd0) begin
            errors++;
            $display("FAIL div0_result: edges=%0d div0=%b ill=%b zlow=%h zhigh=%h, required 1/1/0/0/0", lat, err_div0, err_illegal, zlow, zhigh);
        end
        checks++;
        if (alu_opcode !== m_op || alu_ra !== m_ra || alu_rb !== m_rb) begin
            errors++;
            $display("FAIL div0_alu_kept: op=%h ra=%h rb=%h, required %h/%h/%h", alu_opcode, alu_ra, alu_rb, m_op, m_ra, m_rb);
        end
        take_resp();
    endtask

    task automatic test_illegal();
        int lat;
        logic bad;
        send_req(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0, lat);
        checks++;
        if (lat !== 1 || err_illegal !== 1'b1 || err_div0 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_flag: edges=%0d ill=%b div0=%b, required 1/1/0", lat, err_illegal, err_div0);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 1'b1 || zlow !== 32'd0 || zhigh !== 32'd0 || err_illegal !== 1'b1 ||
                err_div0 !== 1'b0 || req_ready !== 1'b0) bad = 1'b1;
            @(posedge clock); #1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL illegal_hold: response not stable, now valid=%b zlow=%h ill=%b ready=%b", resp_valid, zlow, err_illegal, req_ready);
        end
        checks++;
        if (alu_opcode !== m_op || alu_ra !== m_ra || alu_rb !== m_rb) begin
            errors++;
            $display("FAIL illegal_alu_kept: op=%h ra=%h rb=%h, required %h/%h/%h", alu_opcode, alu_ra, alu_rb, m_op, m_ra, m_rb);
        end
        take_resp();
    endtask

    task automatic test_random();
        int lat;
        int exp_lat;
        int d;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_z;
        logic        exp_ill;
        logic        exp_d0;
        logic        bad;
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            exp_ill = (op > 5'd12);
            exp_d0 = (op == 5'd10) && (b == 32'd0);
            if (exp_ill || exp_d0) begin
                exp_lat = 1;
                exp_z = 64'd0;
            end else begin
                exp_lat = ((op == 5'd9) || (op == 5'd10)) ? MULDIV_LAT + 1 : ALU_LAT + 1;
                exp_z = alu_ref(op, a, b);
                m_op = op; m_ra = a; m_rb = b;
            end
            send_req(op, a, b, lat);
            checks++;
            if (lat !== exp_lat || {zhigh, zlow} !== exp_z || err_illegal !== exp_ill || err_div0 !== exp_d0) begin
                errors++;
                $display("FAIL rand_txn%0d op=%h: edges=%0d z=%h_%h ill=%b d0=%b, required %0d/%h/%b/%b",
                         n, op, lat, zhigh, zlow, err_illegal, err_div0, exp_lat, exp_z, exp_ill, exp_d0);
            end
            checks++;
            if (alu_opcode !== m_op || alu_ra !== m_ra || alu_rb !== m_rb) begin
                errors++;
                $display("FAIL rand_alu%0d: op=%h ra=%h rb=%h, required %h/%h/%h", n, alu_opcode, alu_ra, alu_rb, m_op, m_ra, m_rb);
            end
            d = $urandom_range(0, 3);
            bad = 1'b0;
            for (int i = 0; i < d; i++) begin
                @(posedge clock); #1;
                if (resp_valid !== 1'b1 || {zhigh, zlow} !== exp_z || req_ready !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL rand_stall%0d: valid=%b z=%h_%h ready=%b, required 1/%h/0", n, resp_valid, zhigh, zlow, req_ready, exp_z);
            end
            take_resp();
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        logic seen;
        req_valid = 1'b1;
        req_opcode = OP_MUL; req_ra = 32'd7; req_rb = 32'd9;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || zlow !== 32'd0 || zhigh !== 32'd0 ||
            alu_ra !== 32'd0 || alu_rb !== 32'd0 || alu_opcode !== OP_ADD ||
            err_illegal !== 1'b0 || err_div0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: ready=%b valid=%b ra=%h rb=%h op=%h zlow=%h, required reset values",
                     req_ready, resp_valid, alu_ra, alu_rb, alu_opcode, zlow);
        end
        #2;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_dropped: resp_valid seen=%b, required 0", seen);
        end
        send_req(OP_ADD, 32'd1, 32'd2, lat);
        checks++;
        if (lat !== ALU_LAT + 1 || zlow !== 32'd3 || zhigh !== 32'd0) begin
            errors++;
            $display("FAIL midreset_add: edges=%0d zlow=%h zhigh=%h, required %0d/3/0", lat, zlow, zhigh, ALU_LAT + 1);
        end
        take_resp();
`ifdef ALU_SEQ_STATS_EN
        checks++;
        if (op_count !== 32'd1 || busy_cycles !== 32'd2) begin
            errors++;
            $display("FAIL midreset_stats: op_count=%0d busy=%0d, required 1/2", op_count, busy_cycles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_back_to_back();
        test_mul();
        test_div();
        test_illegal();
        test_random();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
